// File: rtl/ddr2idx_loader.sv
// ddr2idx_loader
// Unpacks DDR beats into LANES index pairs and writes one pair per cycle into
// the per-PE index buffers, either broadcasting to every masked PE or
// scattering round-robin across the masked PEs. A new start aborts any run.
module ddr2idx_loader #(
    parameter int DDR_W     = 512,
    parameter int IDX_W     = 16,
    parameter int IDX_DEPTH = 256,
    parameter int ADDR_W    = $clog2(IDX_DEPTH),
    parameter int PE_NUM    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic [3:0]            conf_mode,
    input  logic [ADDR_W:0]       conf_idx_num,
    input  logic [ADDR_W-1:0]     conf_base_addr,
    input  logic [PE_NUM-1:0]     conf_mask,
    input  logic [DDR_W-1:0]      ddr_data,
    input  logic                  ddr_valid,
    output logic                  ddr_ready,
    output logic [2*IDX_W-1:0]    idx_wr_data,
    output logic [ADDR_W-1:0]     idx_wr_addr,
    output logic [PE_NUM-1:0]     idx_wr_en
);

    localparam int ENT_W  = 2 * IDX_W;
    localparam int LANES  = DDR_W / ENT_W;
    localparam int LANE_W = $clog2(LANES);
    localparam int PTR_W  = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Index of the lowest set bit of the mask (0 when the mask is empty).
    function automatic logic [PTR_W-1:0] lowest_set(input logic [PE_NUM-1:0] m);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = PE_NUM - 1; i >= 0; i--) begin
            if (m[i[PTR_W-1:0]]) begin
                r = i[PTR_W-1:0];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Next set bit strictly after p, wrapping; returns p itself if it is the only one.
    function automatic logic [PTR_W-1:0] next_set(input logic [PE_NUM-1:0] m,
                                                  input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        logic             found;
        int               idx;
        r     = p;
        found = 1'b0;
        for (int k = 1; k <= PE_NUM; k++) begin
            idx = int'(p) + k;
            if (idx >= PE_NUM) begin
                idx = idx - PE_NUM;
            end else begin
                idx = idx;
            end
            if (!found && m[idx[PTR_W-1:0]]) begin
                r     = idx[PTR_W-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return r;
    endfunction

    // Run configuration captured at start
    logic                   cfg_swap_r;
    logic                   cfg_scatter_r;
    logic [CNT_W-1:0]       cfg_num_r;
    logic [ADDR_W-1:0]      cfg_base_r;
    logic [PE_NUM-1:0]      cfg_mask_r;

    // Run state
    logic [1:0]             state_r;
    logic                   done_r;
    logic [LANES-1:0][ENT_W-1:0] beat_r;
    logic                   beat_vld_r;
    logic [LANE_W-1:0]      lane_r;
    logic [CNT_W-1:0]       beats_left_r;
    logic [CNT_W-1:0]       n_r;
    logic [PTR_W-1:0]       ptr_r;
    logic [ADDR_W-1:0]      round_r;

    // Registered write port
    logic [ENT_W-1:0]       wr_data_r;
    logic [ADDR_W-1:0]      wr_addr_r;
    logic [PE_NUM-1:0]      wr_en_r;

    // Combinational helpers
    logic [ENT_W-1:0]       lane_word_s;
    logic [ENT_W-1:0]       entry_s;
    logic [PTR_W-1:0]       ptr_next_s;
    logic                   wrap_s;
    logic                   last_s;
    logic                   ready_s;
    logic                   accept_s;
    logic                   emit_s;
    logic                   empty_s;
    logic [CNT_W-1:0]       beats_s;
    logic                   unused_s;

    // Reserved mode bit is deliberately ignored.
    assign unused_s = conf_mode[3];

    // Lane selection, swap, scatter pointer advance and handshake decode
    always_comb begin
        lane_word_s = beat_r[lane_r];
        if (cfg_swap_r) begin
            entry_s = {lane_word_s[IDX_W-1:0], lane_word_s[ENT_W-1:IDX_W]};
        end else begin
            entry_s = lane_word_s;
        end
        ptr_next_s = next_set(cfg_mask_r, ptr_r);
        wrap_s     = (ptr_next_s <= ptr_r);
        last_s     = (n_r == (cfg_num_r - CNT_W'(1)));
        ready_s    = (state_r == ST_RUN) && (beats_left_r != CNT_W'(0)) &&
                     (!beat_vld_r || (lane_r == LANE_W'(LANES - 1)));
        accept_s   = ready_s && ddr_valid;
        emit_s     = (state_r == ST_RUN) && beat_vld_r;
        empty_s    = (conf_idx_num == CNT_W'(0)) || (conf_mask == PE_NUM'(0));
        beats_s    = CNT_W'(({1'b0, conf_idx_num} + (CNT_W + 1)'(LANES - 1)) >> LANE_W);
    end

    // Run sequencing: start has priority, then per-state beat unpacking and writes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            done_r        <= 1'b1;
            cfg_swap_r    <= 1'b0;
            cfg_scatter_r <= 1'b0;
            cfg_num_r     <= '0;
            cfg_base_r    <= '0;
            cfg_mask_r    <= '0;
            beat_r        <= '0;
            beat_vld_r    <= 1'b0;
            lane_r        <= '0;
            beats_left_r  <= '0;
            n_r           <= '0;
            ptr_r         <= '0;
            round_r       <= '0;
            wr_data_r     <= '0;
            wr_addr_r     <= '0;
            wr_en_r       <= '0;
        end else if (start) begin
            cfg_swap_r    <= (conf_mode[2:1] == 2'b01);
            cfg_scatter_r <= conf_mode[0];
            cfg_num_r     <= conf_idx_num;
            cfg_base_r    <= conf_base_addr;
            cfg_mask_r    <= conf_mask;
            state_r       <= empty_s ? ST_FLUSH : ST_RUN;
            done_r        <= 1'b0;
            beat_vld_r    <= 1'b0;
            lane_r        <= '0;
            beats_left_r  <= empty_s ? CNT_W'(0) : beats_s;
            n_r           <= '0;
            ptr_r         <= lowest_set(conf_mask);
            round_r       <= '0;
            wr_en_r       <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wr_en_r <= '0;
                end
                ST_RUN: begin
                    if (emit_s) begin
                        wr_data_r <= entry_s;
                        n_r       <= n_r + CNT_W'(1);
                        if (cfg_scatter_r) begin
                            wr_en_r   <= PE_NUM'(1) << ptr_r;
                            wr_addr_r <= cfg_base_r + round_r;
                            ptr_r     <= ptr_next_s;
                            if (wrap_s) begin
                                round_r <= round_r + ADDR_W'(1);
                            end
                        end else begin
                            wr_en_r   <= cfg_mask_r;
                            wr_addr_r <= cfg_base_r + n_r[ADDR_W-1:0];
                        end
                        if (last_s) begin
                            // Remaining lanes of the final beat are discarded.
                            state_r    <= ST_FLUSH;
                            beat_vld_r <= 1'b0;
                        end else if (lane_r == LANE_W'(LANES - 1)) begin
                            beat_vld_r <= 1'b0;
                        end else begin
                            lane_r <= lane_r + LANE_W'(1);
                        end
                    end else begin
                        wr_en_r <= '0;
                    end
                    // A new beat lands on the same edge that emits the old lane LANES-1.
                    if (accept_s) begin
                        beat_r       <= ddr_data;
                        beat_vld_r   <= 1'b1;
                        lane_r       <= '0;
                        beats_left_r <= beats_left_r - CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    wr_en_r    <= '0;
                    beat_vld_r <= 1'b0;
                    state_r    <= ST_IDLE;
                    done_r     <= 1'b1;
                end
                default: begin
                    wr_en_r    <= '0;
                    beat_vld_r <= 1'b0;
                    state_r    <= ST_IDLE;
                    done_r     <= 1'b1;
                end
            endcase
        end
    end

    assign done        = done_r;
    assign ddr_ready   = ready_s;
    assign idx_wr_data = wr_data_r;
    assign idx_wr_addr = wr_addr_r;
    assign idx_wr_en   = wr_en_r;

endmodule

// File: tb/tb_ddr2idx_loader.sv
// Directed bench for ddr2idx_loader: expected writes are queued when a beat is
// handed over and compared, cycle-exact, as the write port produces them.
module tb_ddr2idx_loader;

    localparam int LANES = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start;
    logic              done;
    logic [3:0]        conf_mode;
    logic [8:0]        conf_idx_num;
    logic [7:0]        conf_base_addr;
    logic [31:0]       conf_mask;
    logic [15:0][31:0] beat_v;
    logic              ddr_valid;
    logic              ddr_ready;
    logic [31:0]       idx_wr_data;
    logic [7:0]        idx_wr_addr;
    logic [31:0]       idx_wr_en;

    ddr2idx_loader dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .done           (done),
        .conf_mode      (conf_mode),
        .conf_idx_num   (conf_idx_num),
        .conf_base_addr (conf_base_addr),
        .conf_mask      (conf_mask),
        .ddr_data       (beat_v),
        .ddr_valid      (ddr_valid),
        .ddr_ready      (ddr_ready),
        .idx_wr_data    (idx_wr_data),
        .idx_wr_addr    (idx_wr_addr),
        .idx_wr_en      (idx_wr_en)
    );

    typedef struct {
        logic [31:0] en;
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ec = 0;

    logic [3:0]  m_mode;
    int          m_num;
    logic [7:0]  m_base;
    logic [31:0] m_mask;
    int          m_beats, hs_count, run_writes, first_ec, last_ec;
    logic [7:0]  first_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: entry e of the run holding packed word w, due on edge cyc.
    function automatic exp_t model_entry(input int e, input logic [31:0] w, input int cyc);
        exp_t x;
        int   k;
        int   sel;
        int   seen;
        x.cyc  = cyc;
        x.data = (m_mode[2:1] == 2'b01) ? {w[15:0], w[31:16]} : w;
        if (m_mode[0] == 1'b0) begin
            x.en   = m_mask;
            x.addr = 8'(int'(m_base) + e);
        end else begin
            k    = $countones(m_mask);
            sel  = (k > 0) ? e % k : 0;
            seen = 0;
            x.en = 32'h0;
            for (int b = 0; b < 32; b++) begin
                if (m_mask[5'(b)]) begin
                    if (seen == sel) x.en = 32'h1 << b;
                    seen++;
                end
            end
            x.addr = 8'(int'(m_base) + ((k > 0) ? e / k : 0));
        end
        return x;
    endfunction

    // One clock: note handshake, advance, update model, check the write port.
    task automatic cycle();
        logic hs;
        exp_t x;
        hs = (ddr_valid === 1'b1) && (ddr_ready === 1'b1) && (start === 1'b0) && (rst === 1'b0);
        @(posedge clk);
        #1;
        ec++;
        if (rst === 1'b1) begin
            sbq.delete();
        end else begin
            if (start === 1'b1) begin
                sbq.delete();
                m_mode     = conf_mode;
                m_num      = int'(conf_idx_num);
                m_base     = conf_base_addr;
                m_mask     = conf_mask;
                m_beats    = 0;
                hs_count   = 0;
                run_writes = 0;
                first_ec   = -1;
                last_ec    = -1;
            end
            if (hs) begin
                for (int j = 0; j < LANES; j++) begin
                    if (m_beats * LANES + j < m_num)
                        sbq.push_back(model_entry(m_beats * LANES + j, beat_v[4'(j)], ec + 1 + j));
                end
                m_beats++;
                hs_count++;
                for (int j = 0; j < LANES; j++) beat_v[4'(j)] = $urandom();
            end
            if (idx_wr_en !== 32'h0) begin
                if (sbq.size() == 0) begin
                    check("unexpected_write", 64'(idx_wr_en), 64'(0));
                end else begin
                    x = sbq.pop_front();
                    check("wr_en", 64'(idx_wr_en), 64'(x.en));
                    check("wr_addr", 64'(idx_wr_addr), 64'(x.addr));
                    check("wr_data", 64'(idx_wr_data), 64'(x.data));
                    check("wr_cycle", 64'(ec), 64'(x.cyc));
                end
                run_writes++;
                if (first_ec < 0) begin
                    first_ec   = ec;
                    first_addr = idx_wr_addr;
                end
                last_ec = ec;
            end else if (sbq.size() > 0 && sbq[0].cyc <= ec) begin
                check("missing_write", 64'(idx_wr_en), 64'(sbq[0].en));
                void'(sbq.pop_front());
            end
        end
    endtask

    // Pulse start with a configuration, then scramble conf_* to show it was latched.
    task automatic run_start(input logic [3:0] mode, input int num, input logic [7:0] base,
                             input logic [31:0] mask);
        conf_mode      = mode;
        conf_idx_num   = 9'(num);
        conf_base_addr = base;
        conf_mask      = mask;
        start          = 1'b1;
        cycle();
        start          = 1'b0;
        conf_mode      = ~mode;
        conf_idx_num   = 9'(num + 3);
        conf_base_addr = ~base;
        conf_mask      = ~mask;
        check("done_falls_after_start", 64'(done), 64'(0));
    endtask

    task automatic run_until_done(input int max_cyc);
        int i;
        i = 0;
        while (done !== 1'b1 && i < max_cyc) begin
            cycle();
            i++;
        end
        check("run_completes", 64'(done), 64'(1));
    endtask

    initial begin
        int   i;
        int   s_ec;
        int   wcnt;
        int   prev;
        logic rchk;
        int   gaps [4];

        rst = 1'b1; start = 1'b0; ddr_valid = 1'b0;
        conf_mode = 4'h0; conf_idx_num = 9'h0; conf_base_addr = 8'h0; conf_mask = 32'h0;
        for (int j = 0; j < LANES; j++) beat_v[4'(j)] = $urandom();
        m_mode = 4'h0; m_num = 0; m_base = 8'h0; m_mask = 32'h0;
        m_beats = 0; hs_count = 0; run_writes = 0; first_ec = -1; last_ec = -1; first_addr = 8'h0;
        cycle();
        cycle();
        check("rst_done", 64'(done), 64'(1));
        check("rst_ready", 64'(ddr_ready), 64'(0));
        check("rst_wr_en", 64'(idx_wr_en), 64'(0));
        check("rst_wr_data", 64'(idx_wr_data), 64'(0));
        check("rst_wr_addr", 64'(idx_wr_addr), 64'(0));
        rst = 1'b0;
        cycle();

        // Broadcast, 40 entries over 3 beats, valid held high
        ddr_valid = 1'b1;
        run_start(4'b0000, 40, 8'd0, 32'h0000_000F);
        rchk = 1'b0;
        i = 0;
        while (done !== 1'b1 && i < 200) begin
            cycle();
            i++;
            if (hs_count == 3 && !rchk) begin
                check("ready_low_after_last_beat", 64'(ddr_ready), 64'(0));
                rchk = 1'b1;
            end
        end
        check("bc_completes", 64'(done), 64'(1));
        check("bc_done_timing", 64'(ec), 64'(last_ec + 1));
        check("bc_writes", 64'(run_writes), 64'(40));
        check("bc_no_bubbles", 64'(last_ec - first_ec), 64'(39));
        check("bc_first_addr", 64'(first_addr), 64'(0));
        check("bc_sb_empty", 64'(sbq.size()), 64'(0));
        repeat (3) cycle();
        check("bc_beats", 64'(hs_count), 64'(3));

        // Swap with address wrap
        run_start(4'b0010, 10, 8'd250, 32'h0000_0001);
        run_until_done(100);
        check("sw_done_timing", 64'(ec), 64'(last_ec + 1));
        check("sw_writes", 64'(run_writes), 64'(10));
        check("sw_first_addr", 64'(first_addr), 64'(250));
        check("sw_sb_empty", 64'(sbq.size()), 64'(0));
        check("sw_beats", 64'(hs_count), 64'(1));

        // Scatter over PE0, PE5, PE7
        run_start(4'b0001, 7, 8'd5, 32'h0000_00A1);
        run_until_done(100);
        check("sc_writes", 64'(run_writes), 64'(7));
        check("sc_first_addr", 64'(first_addr), 64'(5));
        check("sc_sb_empty", 64'(sbq.size()), 64'(0));

        // Backpressure: valid withheld for 0,2,0,1 cycles when each beat is wanted
        gaps = '{0, 2, 0, 1};
        run_start(4'b0000, 64, 8'd100, 32'h0000_0003);
        wcnt = 0;
        i = 0;
        while (done !== 1'b1 && i < 300) begin
            if (hs_count < 4 && ddr_ready === 1'b1 && wcnt < gaps[hs_count]) begin
                ddr_valid = 1'b0;
                wcnt++;
            end else begin
                ddr_valid = 1'b1;
            end
            prev = hs_count;
            cycle();
            if (hs_count != prev) wcnt = 0;
            i++;
        end
        ddr_valid = 1'b1;
        check("bp_completes", 64'(done), 64'(1));
        check("bp_writes", 64'(run_writes), 64'(64));
        check("bp_span_with_gaps", 64'(last_ec - first_ec), 64'(63 + 3));
        check("bp_beats", 64'(hs_count), 64'(4));
        check("bp_sb_empty", 64'(sbq.size()), 64'(0));

        // Abort at entry 20 with a new base and mask
        run_start(4'b0000, 48, 8'd10, 32'h0000_0001);
        i = 0;
        while (run_writes < 20 && i < 200) begin
            cycle();
            i++;
        end
        check("ab_reached_20", 64'(run_writes), 64'(20));
        run_start(4'b0000, 16, 8'd200, 32'h0000_0002);
        s_ec = ec;
        run_until_done(100);
        check("ab_writes", 64'(run_writes), 64'(16));
        check("ab_first_addr", 64'(first_addr), 64'(200));
        check("ab_first_latency", 64'(first_ec), 64'(s_ec + 2));
        check("ab_sb_empty", 64'(sbq.size()), 64'(0));

        // Zero entries and empty mask: no beats, done back two cycles after start
        run_start(4'b0000, 0, 8'd0, 32'h0000_000F);
        cycle();
        check("zero_done", 64'(done), 64'(1));
        repeat (3) cycle();
        check("zero_no_beats", 64'(hs_count), 64'(0));
        check("zero_ready", 64'(ddr_ready), 64'(0));
        run_start(4'b0001, 8, 8'd0, 32'h0000_0000);
        cycle();
        check("nomask_done", 64'(done), 64'(1));
        check("nomask_no_beats", 64'(hs_count), 64'(0));

        // Reset in the middle of a run
        run_start(4'b0000, 40, 8'd0, 32'h0000_000F);
        repeat (10) cycle();
        rst = 1'b1;
        cycle();
        check("mrst_wr_en", 64'(idx_wr_en), 64'(0));
        check("mrst_done", 64'(done), 64'(1));
        check("mrst_ready", 64'(ddr_ready), 64'(0));
        check("mrst_wr_data", 64'(idx_wr_data), 64'(0));
        check("mrst_wr_addr", 64'(idx_wr_addr), 64'(0));
        rst = 1'b0;
        repeat (5) cycle();
        check("mrst_stays_idle", 64'(done), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr2idx_loader.md
# ddr2idx_loader

Parametrised DDR-to-index-buffer loader for the PE array, sitting between the DDR read stream and the per-PE index buffers. It unpacks each DDR beat into `LANES` index pairs and writes one pair per cycle at full throughput. It optionally swaps the two halves of each pair. Each run either broadcasts every pair to all masked PEs or scatters pairs round-robin across the masked PEs. Runs are bounded by a programmed count and base address, and a run may be aborted by a new `start`.

## Interface
- `DDR_W`, 512: DDR beat width.
- `IDX_W`, 16: width of one index; one entry is `2*IDX_W` bits.
- `IDX_DEPTH`, 256: entries per PE index buffer.
- `ADDR_W`, `bw(IDX_DEPTH)`: buffer address width.
- `PE_NUM`, 32: number of PE index buffers.
- `LANES` (local), `DDR_W/(2*IDX_W)`: entries per beat; must be ≥2 and a power of two.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; latches `conf_*` and begins a run.
- `done` out 1: level; high when idle.
- `conf_mode` in 4: bits [2:1]==2'b01 swap halves; bit 0: 0=broadcast, 1=scatter; bit 3 reserved and ignored.
- `conf_idx_num` in ADDR_W+1: entries to write, 0..IDX_DEPTH (scatter: total across all PEs).
- `conf_base_addr` in ADDR_W: first write address.
- `conf_mask` in PE_NUM: PE enable mask.
- `ddr_data` in DDR_W: beat; lane 0 = bits [2*IDX_W-1:0].
- `ddr_valid` in 1, `ddr_ready` out 1: stream handshake; transfer on valid&&ready.
- `idx_wr_data` out 2*IDX_W: entry; upper half = lane bits [2*IDX_W-1:IDX_W] unless swapped.
- `idx_wr_addr` out ADDR_W: write address.
- `idx_wr_en` out PE_NUM: per-PE write strobe.

## Operation
- States:
  - IDLE (`done`=1).
  - RUN.
  - FLUSH: last entry written; drains to IDLE next cycle.
- `start` is honoured in any state and has priority over all other activity. It aborts any run in progress, drops the held beat, and clears counters. A beat offered in the `start` cycle is not accepted.
- A run with `conf_idx_num`==0 or `conf_mask`==0 consumes no beats; `done` returns high 2 cycles after `start`.
- One beat-holding register (`beat_vld`) and a lane counter 0..LANES-1 per run.
- `ddr_ready` = RUN && remaining-to-accept>0 && (!`beat_vld` || lane==LANES-1). It is combinational from internal registers only, never from `ddr_valid`.
- Entry counter `n` counts entries emitted. The last entry is at `n`==`conf_idx_num`-1. Lanes of the final beat beyond that entry are discarded.
- Broadcast mode:
  - `idx_wr_en`=`conf_mask`.
  - `idx_wr_addr`=`conf_base_addr`+`n` mod IDX_DEPTH (wraps).
- Scatter mode:
  - PE pointer starts at the lowest set bit of the mask.
  - `idx_wr_en` is one-hot at the pointer.
  - After each write the pointer advances to the next set bit, wrapping.
  - A round counter increments on wrap; `idx_wr_addr`=`conf_base_addr`+round mod IDX_DEPTH.
- Swap applies to the data only.
- `conf_*` are sampled only at `start`; later changes have no effect until the next `start`.

## Timing
- Reset values:
  - `done`=1, `ddr_ready`=0, `idx_wr_en`=0.
  - `idx_wr_data`=0, `idx_wr_addr`=0.
  - State IDLE, `beat_vld`=0.
- `done` falls the cycle after `start`.
- Beat accepted at edge E: lane j appears on registered `idx_wr_*` in the cycle after edge E+1+j.
- Sustained rate is 1 entry/cycle with no bubbles while `ddr_valid` is held high, because the next beat is accepted at the edge that registers lane LANES-1.
- A `ddr_valid` gap of g cycles produces exactly a g-cycle gap in `idx_wr_en`.
- Final write is visible in cycle F; `done`=1 from cycle F+1.
- `ddr_ready`=0 from the edge at which the last needed beat is accepted.
- `rst` mid-run returns all outputs to reset values at the next edge; no further writes occur.
- `idx_wr_data` and `idx_wr_addr` hold their last value when `idx_wr_en`=0.

## Test plan
- Broadcast run, LANES=16, `conf_idx_num`=40, base 0, mask 0x0000_000F, valid always high:
  - exactly 3 beats accepted;
  - 40 consecutive writes, addr 0..39, en=0xF;
  - lanes 8..15 of beat 3 dropped;
  - `done` high the cycle after addr 39.
- Swap plus wrap, mode=4'b0010, base 250, `conf_idx_num`=10:
  - addrs 250..255 then 0..3;
  - data halves swapped versus lanes.
- Scatter, mode=4'b0001, mask 0b1010_0001, `conf_idx_num`=7:
  - en sequence PE0, PE5, PE7, PE0, PE5, PE7, PE0;
  - addrs base, base, base, base+1, base+1, base+1, base+2.
- Backpressure: `ddr_valid` toggled 1,0,0,1 per beat:
  - write gaps exactly match the valid gaps;
  - no lost or duplicated entry (scoreboard against a packed reference).
- Abort and edge cases:
  - `start` mid-run at entry 20 with a new base: next write uses the new base at entry 0, and no old-beat lanes appear.
  - `conf_idx_num`=0: zero beats taken, `done` back high 2 cycles after `start`.
  - `rst` asserted mid-run: `idx_wr_en`=0 and `done`=1 next cycle.
